// File: rtl/vram_text_writer.sv
// Terminal-style VRAM write sequencer feeding CHR_GEN: PUTC/LOCATE/FILL commands,
// cursor tracking with wrap, CR/LF/BS handling and blank-clearing of each new line.
module vram_text_writer #(
    parameter int unsigned C_COL_W = 5,
    parameter int unsigned C_ROW_W = 5,
    parameter logic [7:0]  C_BLANK = 8'h20
) (
    input  logic                       CK_i,
    input  logic                       XAR_i,
    input  logic                       CK_EE_i,
    input  logic                       CMD_VLD_i,
    output logic                       CMD_RDY_o,
    input  logic [1:0]                 CMD_OPs_i,
    input  logic [C_COL_W+C_ROW_W-1:0] CMD_DATs_i,
    output logic [7:0]                 VRAM_WDs_o,
    output logic [C_COL_W+C_ROW_W-1:0] VRAM_WAs_o,
    output logic                       VRAM_WE_o,
    output logic [C_COL_W+C_ROW_W-1:0] CURSOR_o
);

    localparam int unsigned AW = C_COL_W + C_ROW_W;
    localparam logic [AW-1:0]      AddrOne = AW'(1);
    localparam logic [C_ROW_W-1:0] RowOne  = C_ROW_W'(1);
    localparam logic [C_COL_W-1:0] ColZero = '0;

    localparam logic [1:0] OpPutc   = 2'd0;
    localparam logic [1:0] OpLocate = 2'd1;
    localparam logic [1:0] OpFill   = 2'd2;

    typedef enum logic [1:0] {StIdle, StWr, StLclr, StFill} state_t;

    state_t          r_state, w_state_d;
    logic [7:0]      r_wd, w_wd_d;
    logic [AW-1:0]   r_wa, w_wa_d;
    logic            r_we, w_we_d;
    logic [AW-1:0]   r_cursor, w_cursor_d;

    logic [C_ROW_W-1:0] w_row;
    logic [C_ROW_W-1:0] w_row_inc;
    logic [C_COL_W-1:0] w_col;
    logic [7:0]         w_char;

    assign w_row     = r_cursor[AW-1:C_COL_W];
    assign w_col     = r_cursor[C_COL_W-1:0];
    assign w_row_inc = w_row + RowOne;
    assign w_char    = CMD_DATs_i[7:0];

    always_comb begin
        w_state_d  = r_state;
        w_wd_d     = r_wd;
        w_wa_d     = r_wa;
        w_we_d     = r_we;
        w_cursor_d = r_cursor;
        unique case (r_state)
            StIdle: begin
                if (CMD_VLD_i) begin
                    unique case (CMD_OPs_i)
                        OpPutc: begin
                            case (w_char)
                                8'h0D: w_cursor_d = {w_row, ColZero};
                                8'h0A: begin
                                    w_cursor_d = {w_row_inc, ColZero};
                                    w_state_d  = StLclr;
                                    w_we_d     = 1'b1;
                                    w_wa_d     = {w_row_inc, ColZero};
                                    w_wd_d     = C_BLANK;
                                end
                                8'h08: begin
                                    // col>0 so the decrement never borrows into the row
                                    if (w_col != ColZero) w_cursor_d = r_cursor - AddrOne;
                                end
                                default: begin
                                    w_state_d = StWr;
                                    w_we_d    = 1'b1;
                                    w_wa_d    = r_cursor;
                                    w_wd_d    = w_char;
                                end
                            endcase
                        end
                        OpLocate: w_cursor_d = CMD_DATs_i;
                        OpFill: begin
                            w_state_d = StFill;
                            w_we_d    = 1'b1;
                            w_wa_d    = '0;
                            w_wd_d    = w_char;
                        end
                        default: ;
                    endcase
                end
            end
            StWr: begin
                // Full-width increment carries col overflow into row and wraps row
                w_cursor_d = r_cursor + AddrOne;
                if (&w_col) begin
                    w_state_d = StLclr;
                    w_we_d    = 1'b1;
                    w_wa_d    = {w_row_inc, ColZero};
                    w_wd_d    = C_BLANK;
                end else begin
                    w_state_d = StIdle;
                    w_we_d    = 1'b0;
                end
            end
            StLclr: begin
                if (&r_wa[C_COL_W-1:0]) begin
                    w_state_d = StIdle;
                    w_we_d    = 1'b0;
                end else begin
                    w_wa_d = r_wa + AddrOne;
                end
            end
            StFill: begin
                if (&r_wa) begin
                    w_state_d  = StIdle;
                    w_we_d     = 1'b0;
                    w_cursor_d = '0;
                end else begin
                    w_wa_d = r_wa + AddrOne;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            r_state  <= StIdle;
            r_wd     <= '0;
            r_wa     <= '0;
            r_we     <= 1'b0;
            r_cursor <= '0;
        end else if (CK_EE_i) begin
            r_state  <= w_state_d;
            r_wd     <= w_wd_d;
            r_wa     <= w_wa_d;
            r_we     <= w_we_d;
            r_cursor <= w_cursor_d;
        end
    end

    assign CMD_RDY_o  = (r_state == StIdle);
    assign VRAM_WDs_o = r_wd;
    assign VRAM_WAs_o = r_wa;
    assign VRAM_WE_o  = r_we;
    assign CURSOR_o   = r_cursor;

endmodule

// File: tb/tb_vram_text_writer.sv
// Self-checking bench for vram_text_writer: a row/col text-screen model predicts the
// write stream and cursor; a negedge monitor checks every committed write and EE hold.
module tb_vram_text_writer;

    localparam int AW   = 10;
    localparam int NCOL = 32;
    localparam int NROW = 32;

    logic            clk = 1'b0;
    logic            xar = 1'b0;
    logic            ee  = 1'b0;
    logic            vld = 1'b0;
    logic [1:0]      op  = 2'd0;
    logic [AW-1:0]   dat = '0;
    logic            rdy;
    logic [7:0]      wd;
    logic [AW-1:0]   wa;
    logic            we;
    logic [AW-1:0]   cur;

    vram_text_writer #(
        .C_COL_W (5),
        .C_ROW_W (5),
        .C_BLANK (8'h20)
    ) u_dut (
        .CK_i       (clk),
        .XAR_i      (xar),
        .CK_EE_i    (ee),
        .CMD_VLD_i  (vld),
        .CMD_RDY_o  (rdy),
        .CMD_OPs_i  (op),
        .CMD_DATs_i (dat),
        .VRAM_WDs_o (wd),
        .VRAM_WAs_o (wa),
        .VRAM_WE_o  (we),
        .CURSOR_o   (cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  m_row    = 0;
    int  m_col    = 0;
    bit  in_reset = 1'b1;
    int  ee_mode  = 1;
    int  ee_ctr   = 0;
    int  wr_cnt   = 0;

    task automatic check(input string name, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int pack_outs();
        return {2'b00, we, rdy, wd, wa, cur};
    endfunction

    // Screen model: what must be written and where the cursor ends up
    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input int row);
        for (int c = 0; c < NCOL; c++) push_wr(row * NCOL + c, 'h20);
    endtask

    task automatic model_cmd(input int o, input int d);
        int ch;
        ch = d & 'hFF;
        case (o)
            0: begin
                if (ch == 'h0D) m_col = 0;
                else if (ch == 'h0A) begin
                    m_col = 0;
                    m_row = (m_row + 1) % NROW;
                    push_line(m_row);
                end else if (ch == 'h08) begin
                    if (m_col > 0) m_col--;
                end else begin
                    push_wr(m_row * NCOL + m_col, ch);
                    m_col++;
                    if (m_col == NCOL) begin
                        m_col = 0;
                        m_row = (m_row + 1) % NROW;
                        push_line(m_row);
                    end
                end
            end
            1: begin
                m_row = (d / NCOL) % NROW;
                m_col = d % NCOL;
            end
            2: begin
                for (int a = 0; a < NCOL * NROW; a++) push_wr(a, ch);
                m_row = 0;
                m_col = 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ee_ctr++;
            case (ee_mode)
                0:       ee = 1'($urandom_range(0, 1));
                1:       ee = 1'b1;
                default: ee = ((ee_ctr % 4) == 0);
            endcase
        end
    end

    // A write is committed on each EE edge while WE is high
    int snap    = 0;
    bit last_ee = 1'b1;
    always @(negedge clk) begin
        wr_t e;
        if (in_reset) begin
            last_ee = 1'b1;
        end else begin
            if (!last_ee) check("ee_hold", pack_outs(), snap);
            check("we_in_idle", int'(we & rdy), 0);
            if (ee && we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                             wa, wd);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wa), e.addr);
                    check("wr_data", int'(wd), e.data);
                end
            end
            snap    = pack_outs();
            last_ee = ee;
        end
    end

    task automatic send(input int o, input int d);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #2;
        vld = 1'b1;
        op  = 2'(o);
        dat = AW'(d);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = ee && rdy;
            @(posedge clk);
            #2;
        end
        vld = 1'b0;
        op  = 2'($urandom);
        dat = AW'($urandom);
        if (!acc) check("accept_timeout", 0, 1);
        else model_cmd(o, d);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = rdy && (exp_q.size() == 0);
        end
        if (!done) begin
            check("idle_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("cursor", int'(cur), m_row * NCOL + m_col);
    endtask

    initial begin
        int base;
        logic [7:0] ch;
        int r;

        // 1: reset values, then idle with no writes
        ee_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_we", int'(we), 0);
        check("rst_wa", int'(wa), 0);
        check("rst_wd", int'(wd), 0);
        check("rst_cursor", int'(cur), 0);
        check("rst_rdy", int'(rdy), 1);
        xar      = 1'b1;
        in_reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("idle_we", int'(we), 0);

        // 2: single printable char
        send(0, 'h041);
        check("t2_model_qsize", exp_q.size(), 1);
        if (exp_q.size() > 0) check("t2_model_wr", exp_q[0].addr * 256 + exp_q[0].data, 'h41);
        wait_idle(100);
        check("t2_cursor", int'(cur), 1);
        check("t2_rdy", int'(rdy), 1);

        // 3: char at end of row forces a line clear of the next row
        ee_mode = 0;
        send(1, 'h01F);
        wait_idle(100);
        send(0, 'h042);
        check("t3_model_qsize", exp_q.size(), 33);
        if (exp_q.size() > 1) check("t3_model_blank0", exp_q[1].addr, 'h020);
        wait_idle(400);
        check("t3_cursor", int'(cur), 'h020);

        // 4: LF from the last row wraps to row 0; BS at col 0 is a no-op
        send(1, 'h3E5);
        wait_idle(100);
        send(0, 'h00A);
        check("t4_model_qsize", exp_q.size(), 32);
        if (exp_q.size() > 0) check("t4_model_blank0", exp_q[0].addr, 0);
        wait_idle(400);
        check("t4_cursor", int'(cur), 0);
        send(0, 'h008);
        wait_idle(100);
        check("t4_bs_cursor", int'(cur), 0);

        // 5: full-screen fill with EE every 4th clock
        ee_mode = 2;
        send(1, 'h155);
        wait_idle(100);
        base = wr_cnt;
        send(2, 'h02A);
        check("t5_model_qsize", exp_q.size(), 1024);
        wait_idle(6000);
        check("t5_writes", wr_cnt - base, 1024);
        check("t5_cursor", int'(cur), 0);
        check("t5_rdy", int'(rdy), 1);

        // Randomized command stream
        ee_mode = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                ch = 8'($urandom_range(0, 255));
                if (ch == 8'h08 || ch == 8'h0A || ch == 8'h0D) ch = 8'h41;
                send(0, int'({2'($urandom), ch}));
            end else if (r < 70) send(0, 'h00D | ($urandom_range(0, 3) << 8));
            else if (r < 80) send(0, 'h00A);
            else if (r < 88) send(0, 'h008);
            else if (r < 96) send(1, $urandom_range(0, 1023));
            else send(3, $urandom_range(0, 1023));
            wait_idle(400);
        end

        // 6: reset in the middle of a fill
        ee_mode = 1;
        base = wr_cnt;
        send(2, 'h055);
        for (int i = 0; i < 300 && (wr_cnt - base) < 100; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_progress", wr_cnt - base, 100);
        in_reset = 1'b1;
        xar      = 1'b0;
        #1;
        check("t6_we", int'(we), 0);
        check("t6_wa", int'(wa), 0);
        check("t6_wd", int'(wd), 0);
        check("t6_cursor", int'(cur), 0);
        check("t6_rdy", int'(rdy), 1);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        repeat (2) @(posedge clk);
        #2;
        xar      = 1'b1;
        in_reset = 1'b0;
        send(0, 'h041);
        if (exp_q.size() > 0) check("t6_model_addr", exp_q[0].addr, 0);
        wait_idle(100);
        check("t6_cursor_after", int'(cur), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
